muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  RV32M execute-stage unit. Accepts one M-extension op from EX (funct3 + rs1/rs2).
//  Multiplies in a registered cycle; divides with an internal iterative unsigned core.
//  Stalls the pipeline through busy, then returns a 32-bit result with a one-cycle done pulse.
//  Applies RISC-V signedness, divide-by-zero and overflow rules.
// PARAMETERS
//  XLEN            32  operand/result width; only 32 is supported
//  DIV_RADIX_LOG2  1   quotient bits retired per divide cycle (1 or 2); N = XLEN/DIV_RADIX_LOG2
// PORTS
//  clk     in   1     single clock, rising edge
//  rst     in   1     asynchronous, active-high reset
//  start   in   1     op request; accepted only when busy==0
//  funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1     in   XLEN  dividend / multiplicand
//  rs2     in   XLEN  divisor / multiplier
//  flush   in   1     abort in-flight op (pipeline redirect)
//  busy    out  1     high from the cycle after acceptance until done; EX stalls on busy|start
//  done    out  1     one-cycle pulse; result valid this cycle
//  result  out  XLEN  last completed result; held until the next done
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, all internal operand/remainder regs=0.
//  FSM: IDLE -> MUL -> DONE; IDLE -> DSET -> DITER(xN) -> DFIX -> DONE; DONE -> IDLE.
//  Accept: start&&state==IDLE&&!flush at edge T. Operands and funct3 latch; start while busy is ignored.
//  MUL*: operands sign/zero-extended to 33b (MULH s*s, MULHSU s*u, MULHU u*u).
//   The 66b product registers at T+1. MUL returns bits[31:0]; others return [63:32]. done in cycle T+2.
//  DIV*/REM*: DSET latches |rs1| and |rs2| (signed ops), clears remainder, sets count=N-1.
//   DITER runs restoring shift-subtract, DIV_RADIX_LOG2 bits per cycle.
//   DFIX negates quotient if sign(rs1)^sign(rs2), negates remainder if sign(rs1) (signed only).
//   done in cycle T+N+2 (T+34 at defaults).
//  Special cases (final result, always): divisor==0 -> quotient=32'hFFFF_FFFF, remainder=rs1.
//   Signed rs1=32'h8000_0000, rs2=-1 -> quotient=32'h8000_0000, remainder=0.
//  busy=1 in MUL, DSET, DITER, DFIX; busy=0 in DONE and IDLE. A new start is accepted the cycle after done.
//  flush: synchronous; any state -> IDLE next edge, no done, result unchanged.
//   flush with start in the same cycle: flush wins and start is dropped.
//  rst mid-operation: immediate return to reset values; no done.
//  Width: all internal arithmetic is unsigned on explicitly extended vectors; no implicit truncation.
// CONFIGURATION
//  `MULDIV_FASTPATH_EN defined: divisor==0 or signed overflow is detected in DSET.
//   The FSM then goes DSET->DFIX with the override result; done at T+3.
//  Undefined: special cases run all N iterations; DFIX overrides the result; done at T+N+2.
//  Results are identical either way; only latency differs.
// STRUCTURE
//  md_pkg: funct3 localparams (F3_MUL..F3_REMU), FSM state codes, XLEN default.
//   md_pkg also holds an is_signed_div(funct3) function.
//  Sub-module md_div_iter: unsigned iterative divider core.
//   Ports: clk, rst, load, dividend, divisor, step, quotient, remainder, last.
//   muldiv_seq owns the FSM, sign handling, special cases and the multiplier.
// TESTING
//  1 MUL rs1=7, rs2=-3 (32'hFFFF_FFFD) -> done at T+2, result=32'hFFFF_FFEB; busy high only in T+1.
//  2 MULH rs1=rs2=32'h8000_0000 -> 32'h4000_0000.
//    MULHSU rs1=-1, rs2=32'hFFFF_FFFF -> 32'hFFFF_FFFF. MULHU same operands -> 32'hFFFF_FFFE.
//  3 DIV rs1=-20, rs2=3 -> -6 (32'hFFFF_FFFA), done at T+34.
//    REM same operands -> -2. DIVU 20/3 -> 6. REMU 20/3 -> 2.
//  4 DIV x/0 with rs1=-5 -> 32'hFFFF_FFFF. REM x/0 -> 32'hFFFF_FFFB.
//    DIV 32'h8000_0000/-1 -> 32'h8000_0000. REM of the same -> 0.
//    Latency T+3 with the macro, T+34 without.
//  5 Start DIVU, flush at T+10 -> no done, busy low at T+11, result keeps the prior value.
//    New MUL 2*3 accepted at T+11 -> 6 at T+13.
//  6 Assert rst mid-DITER -> busy, done and result are 0 asynchronously.
//    Start held high while busy -> only one done.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared constants for the RV32M multiply/divide unit.
//   XLEN_DEF     default operand/result width
//   F3_*         funct3 encodings of the eight M-extension ops
//   S_*          FSM state codes used by muldiv_seq
//   is_signed_div(funct3) -> 1 for DIV and REM
package md_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DSET  = 3'd2;
  localparam logic [2:0] S_DITER = 3'd3;
  localparam logic [2:0] S_DFIX  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic is_signed_div(input logic [2:0] funct3);
    return (funct3 == F3_DIV) || (funct3 == F3_REM);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: unsigned restoring divider core, RADIX_LOG2 quotient bits per step.
//   clk, rst   clock, asynchronous active-high reset
//   load       capture dividend/divisor, clear remainder and retire the first step
//   dividend   unsigned dividend (XLEN)
//   divisor    unsigned divisor (XLEN)
//   step       retire the next RADIX_LOG2 quotient bits
//   quotient   running / final quotient
//   remainder  running / final remainder
//   last       the step taken this cycle is the final one
// The load cycle already retires the first step, so a full divide is one load
// plus N-1 steps (N = XLEN/RADIX_LOG2); the step counter starts at N-1.
module md_div_iter
  import md_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            step,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int N  = XLEN / RADIX_LOG2;
  localparam int CW = $clog2(N);

  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [CW-1:0]   cnt_q;

  // One radix step: shift the next dividend bit into the partial remainder and
  // subtract the divisor whenever it fits. The partial remainder stays below the
  // divisor, so its 33-bit form always fits back into XLEN bits after each bit.
  function automatic logic [2*XLEN-1:0] div_round(input logic [XLEN-1:0] r_in,
                                                  input logic [XLEN-1:0] q_in,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN:0]   t;
    logic [XLEN-1:0] r, q;
    r = r_in;
    q = q_in;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      t = {r, q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (t >= {1'b0, d}) begin
        t    = t - {1'b0, d};
        q[0] = 1'b1;
      end
      r = t[XLEN-1:0];
    end
    return {r, q};
  endfunction

  always_comb begin
    if (load) {rem_nx, quo_nx} = div_round('0, dividend, divisor);
    else      {rem_nx, quo_nx} = div_round(rem_q, quo_q, div_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      div_q <= divisor;
      cnt_q <= CW'(N - 1);
    end else if (step && (cnt_q != '0)) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M execute-stage multiply/divide unit.
//   clk, rst   clock, asynchronous active-high reset
//   start      op request, accepted only in IDLE and without flush
//   funct3     M-extension op select (MUL..REMU)
//   rs1, rs2   operands
//   flush      abort any in-flight op; no done, result untouched
//   busy       high while an op is in flight (MUL, DSET, DITER, DFIX)
//   done       one-cycle pulse, result valid
//   result     last completed result, held until the next done
// Multiplies take one registered cycle; divides run on md_div_iter with sign
// fix-up and RISC-V divide-by-zero / overflow results applied in DFIX.
// Build option: define MULDIV_FASTPATH_EN to skip the divide iterations when the
// divisor is zero or the signed op overflows (same result, shorter latency).
module muldiv_seq
  import md_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int DIV_RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [2:0]      state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;

  // ---------------- multiplier ----------------
  // Operands are extended to XLEN+1 bits with per-op signedness; the product of
  // two 33-bit values only repeats its sign above bit 63, so 64 bits are kept.
  logic                sa, sb;
  logic [XLEN:0]       a33, b33;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     mul_res;

  assign sa   = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
  assign sb   = (f3_q == F3_MULH);
  assign a33  = {sa & a_q[XLEN-1], a_q};
  assign b33  = {sb & b_q[XLEN-1], b_q};
  assign prod = {{(XLEN-1){a33[XLEN]}}, a33} * {{(XLEN-1){b33[XLEN]}}, b33};
  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // ---------------- divider ----------------
  logic            sd, neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b, core_q, core_r, q_fix, r_fix, div_res;
  logic            div_load, div_step, div_last;

  assign sd    = is_signed_div(f3_q);
  assign neg_a = sd & a_q[XLEN-1];
  assign neg_b = sd & b_q[XLEN-1];
  assign abs_a = neg_a ? -a_q : a_q;
  assign abs_b = neg_b ? -b_q : b_q;
  assign div0  = (b_q == '0);
  assign ovf   = sd && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  assign div_load = (state == S_DSET)  && !flush;
  assign div_step = (state == S_DITER) && !flush;

  md_div_iter #(
    .XLEN       (XLEN),
    .RADIX_LOG2 (DIV_RADIX_LOG2)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .step      (div_step),
    .quotient  (core_q),
    .remainder (core_r),
    .last      (div_last)
  );

  // Special cases replace whatever the core produced.
  // NOTE: every output of this block gets a value on every path first, so no
  // latch can be inferred.
  always_comb begin
    q_fix = core_q;
    r_fix = core_r;
    if (div0) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf) begin
      q_fix = {1'b1, {(XLEN-1){1'b0}}};
      r_fix = '0;
    end else begin
      if (neg_a ^ neg_b) q_fix = -core_q;
      if (neg_a)         r_fix = -core_r;
    end
  end

  // REM/REMU have funct3[1] set, DIV/DIVU do not.
  assign div_res = f3_q[1] ? r_fix : q_fix;

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          f3_q  <= funct3;
          a_q   <= rs1;
          b_q   <= rs2;
          state <= funct3[2] ? S_DSET : S_MUL;
        end
        S_MUL: begin
          result <= mul_res;
          state  <= S_DONE;
        end
`ifdef MULDIV_FASTPATH_EN
        S_DSET:  state <= (div0 || ovf) ? S_DFIX : S_DITER;
`else
        S_DSET:  state <= S_DITER;
`endif
        S_DITER: if (div_last) state <= S_DFIX;
        S_DFIX: begin
          result <= div_res;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_MUL) || (state == S_DSET) ||
                (state == S_DITER) || (state == S_DFIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with a cycle-level reference model.
// The driver posts each accepted op; one compare process checks busy, done and
// result against the model on every falling edge and during reset.
module tb_muldiv_seq;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // driver -> compare mailbox
  int          req_cnt = 0;
  int          kill_cnt = 0;
  int          req_acc = 0;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_a = '0, req_b = '0, req_lit = '0;

  // compare-process state
  int          c_req_seen = 0, c_kill_seen = 0, c_done_at = 0;
  logic        c_pend = 1'b0;
  logic [31:0] c_exp = '0, c_last = '0;

  // Reference result straight from the RISC-V M-extension definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      F3_MUL:    begin sp = sa * sb; return sp[31:0];  end
      F3_MULH:   begin sp = sa * sb; return sp[63:32]; end
      F3_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
      F3_MULHU:  begin up = ua * ub; return up[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the done cycle.
  function automatic int latency(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    logic special;
    special = (b == 0) ||
              ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (!f[2]) return 2;
`ifdef MULDIV_FASTPATH_EN
    if (special) return 3;
`else
    if (special) return 34;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Compare process: the only place comparisons happen.
  initial begin : compare
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_result", result,    32'h0);
        c_pend = 1'b0;
        c_last = '0;
      end else begin
        cyc++;
        if (kill_cnt != c_kill_seen) begin
          c_kill_seen = kill_cnt;
          c_pend      = 1'b0;
        end
        if (req_cnt != c_req_seen) begin
          c_req_seen = req_cnt;
          c_exp      = model(req_f3, req_a, req_b);
          check("model_pin", c_exp, req_lit);
          c_pend     = 1'b1;
          c_done_at  = req_acc + latency(req_f3, req_a, req_b);
        end
        check("busy", 32'(busy), 32'(c_pend && cyc < c_done_at));
        check("done", 32'(done), 32'(c_pend && cyc == c_done_at));
        if (c_pend && cyc == c_done_at) begin
          check("result", result, c_exp);
          c_last = c_exp;
          c_pend = 1'b0;
        end else begin
          check("result_hold", result, c_last);
        end
      end
    end
  end

  // Present an op for one cycle (or keep start high when hold is set).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input logic hold);
    @(negedge clk);
    flush  = 1'b0;
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    @(posedge clk);
    req_f3  = f;
    req_a   = a;
    req_b   = b;
    req_lit = lit;
    req_acc = cyc;
    req_cnt++;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : driver
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0); wait_done();
    run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0); wait_done();
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done();
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); wait_done();

    run_op(F3_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0); wait_done();
    run_op(F3_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0); wait_done();
    run_op(F3_DIVU, 32'd20,        32'd3, 32'd6,         1'b0); wait_done();
    run_op(F3_REMU, 32'd20,        32'd3, 32'd2,         1'b0); wait_done();

    run_op(F3_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b0); wait_done();
    run_op(F3_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0); wait_done();
    run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); wait_done();
    run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0); wait_done();
    run_op(F3_DIVU, 32'd20,        32'd0,         32'hFFFF_FFFF, 1'b0); wait_done();
    run_op(F3_REMU, 32'd20,        32'd0,         32'd20,        1'b0); wait_done();

    // Flush in cycle T+10 of a divide, then a MUL accepted in T+11.
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    kill_cnt++;
    run_op(F3_MUL, 32'd2, 32'd3, 32'd6, 1'b0); wait_done();

    // Asynchronous reset in the middle of the divide iterations.
    run_op(F3_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Start held high through the whole op: exactly one done.
    run_op(F3_REMU, 32'd1000, 32'd7, 32'd6, 1'b1); wait_done();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
